// File: rtl/div_iter_seq_if.sv
// Request/response bundle for the iterative divider: operands and start in, status and results out.
// master drives requests, slave is the divider.
interface div_iter_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_iter_seq.sv
// Sequential restoring divider, one quotient bit per clock; optional signed mode via DIV_SIGNED_EN.
// Latency: WIDTH+1 cycles from accepted start to done (1 cycle for divide by zero).
// Backpressure: none; start is only accepted in IDLE and ignored otherwise.
module div_iter_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    div_iter_seq_if.slave io
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] q_sr_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dbz_q;
    logic             divisor_zero;

    logic [2*WIDTH:0] shift_w;
    logic [WIDTH:0]   trial;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    logic             busy_q, done_q, dbz_out_q;
    logic [WIDTH-1:0] quot_q, rem_out_q;

    assign divisor_zero = (io.divisor == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    accept  = 1'b1;
                    state_d = divisor_zero ? DONE : CALC;
                end
            end
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifted {remainder, quotient}; the trial subtract sign decides the next quotient bit.
    assign shift_w = {rem_q, q_sr_q} << 1;
    assign trial   = shift_w[2*WIDTH:WIDTH] - {1'b0, dvs_q};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic q_neg_q, r_neg_q;

    assign a_neg = io.signed_op & io.dividend[WIDTH-1];
    assign b_neg = io.signed_op & io.divisor[WIDTH-1];
    assign a_mag = a_neg ? (~io.dividend + 1'b1) : io.dividend;
    assign b_mag = b_neg ? (~io.divisor + 1'b1) : io.divisor;
    assign q_res = q_neg_q ? (~q_sr_q + 1'b1) : q_sr_q;
    assign r_res = r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
        end
    end
`else
    logic signed_op_unused;

    assign signed_op_unused = io.signed_op;
    assign a_mag = io.dividend;
    assign b_mag = io.divisor;
    assign q_res = q_sr_q;
    assign r_res = rem_q[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            q_sr_q    <= '0;
            dvs_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
        end else begin
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == DONE);
            if (accept) begin
                // Divide by zero keeps the raw dividend so it can be returned unmodified.
                q_sr_q <= divisor_zero ? io.dividend : a_mag;
                dvs_q  <= b_mag;
                rem_q  <= '0;
                cnt_q  <= CW'(WIDTH - 1);
                dbz_q  <= divisor_zero;
            end else if (state_q == CALC) begin
                rem_q  <= trial[WIDTH] ? shift_w[2*WIDTH:WIDTH] : trial;
                q_sr_q <= shift_w[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
                cnt_q  <= cnt_q - 1'b1;
            end
            if (state_q == DONE) begin
                dbz_out_q <= dbz_q;
                quot_q    <= dbz_q ? '1 : q_res;
                rem_out_q <= dbz_q ? q_sr_q : r_res;
            end
        end
    end

    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.quotient    = quot_q;
    assign io.remainder   = rem_out_q;
    assign io.div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_div_iter_seq.sv
// Directed-vector bench for div_iter_seq (WIDTH=8) with a queue scoreboard checked on every done pulse.
module tb_div_iter_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done_cnt;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    div_iter_seq_if #(.WIDTH(8)) bus ();

    div_iter_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with q=%0h r=%0h, want no done",
                         bus.quotient, bus.remainder);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_quotient"}, bus.quotient, e.q);
                chk({e.name, "_remainder"}, bus.remainder, e.r);
                chk({e.name, "_div_by_zero"}, bus.div_by_zero, e.z);
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sop,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int exp_lat, input bit inject, input string name);
        int k;
        int bc;
        exp_t e;
        e.q = eq; e.r = er; e.z = ez; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = sop;
        @(posedge clk);
        #1 bus.start = 1'b0;
        k  = 0;
        bc = 0;
        while (1) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.busy) bc++;
            if (bus.done) break;
            if (inject && k == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'h10;
                bus.divisor  = 8'h03;
            end
            if (inject && k == 4) bus.start = 1'b0;
            if (k > 40) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got no done in %0d cycles, want done", name, k);
                return;
            end
        end
        chk({name, "_latency"}, k, exp_lat);
        chk({name, "_busy_cycles"}, bc, exp_lat);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_done_falls"}, bus.done, 1'b0);
        chk({name, "_busy_falls"}, bus.busy, 1'b0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        done_cnt      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_quotient", bus.quotient, 8'h00);
        chk("rst_remainder", bus.remainder, 8'h00);
        chk("rst_div_by_zero", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 9, 1'b0, "u100_7");
        run_op(8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 9, 1'b0, "uFF_01");
        run_op(8'h03, 8'h10, 1'b0, 8'h00, 8'h03, 1'b0, 9, 1'b0, "u03_10");
        run_op(8'h05, 8'h00, 1'b0, 8'hFF, 8'h05, 1'b1, 1, 1'b0, "dbz05");
`ifdef DIV_SIGNED_EN
        run_op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9, 1'b0, "sF9_02");
        run_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9, 1'b0, "s80_FF");
`else
        run_op(8'hF9, 8'h02, 1'b1, 8'h7C, 8'h01, 1'b0, 9, 1'b0, "sF9_02");
        run_op(8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 9, 1'b0, "s80_FF");
`endif
        // 200 / 9 = 22 r 2; the extra start pulse mid-operation must be ignored.
        run_op(8'd200, 8'd9, 1'b0, 8'd22, 8'd2, 1'b0, 9, 1'b1, "hs200_9");

        // Reset in iteration 4 of 50 / 3: all outputs clear, no done pulse.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.dividend  = 8'd50;
        bus.divisor   = 8'd3;
        bus.signed_op = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_quotient", bus.quotient, 8'h00);
        chk("midrst_remainder", bus.remainder, 8'h00);
        chk("midrst_div_by_zero", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_done", done_cnt, 7);

        run_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 9, 1'b0, "post_rst_100_7");

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("final_done_count", done_cnt, 8);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter_seq.md
# div_iter_seq

Parametrised sequential restoring divider: the multi-cycle successor to the single-step combinational division loop. Retires one quotient bit per clock using an internal subtract/compare step and a start/done handshake. Operands are WIDTH bits wide, with optional signed operation. The block sits beside the m×n multiplier as the datapath's division unit and returns quotient, remainder and a divide-by-zero flag.

## Interface
- WIDTH, 32: operand, quotient and remainder width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- signed_op  in  1  1 = two's-complement operands; sampled with start; honoured only when DIV_SIGNED_EN is defined.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high from the cycle after acceptance through the cycle done is high.
- done  out  1  one-cycle pulse; results valid on this cycle.
- quotient  out  WIDTH  registered result; held until the next done.
- remainder  out  WIDTH  registered result; held until the next done.
- div_by_zero  out  1  registered flag; same timing as quotient.

## Operation
- States:
  - IDLE → CALC: on start with divisor != 0.
  - IDLE → DONE: on start with divisor == 0.
  - CALC → DONE: after WIDTH iterations.
  - DONE → IDLE: unconditionally.
- Acceptance:
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits).
  - Load the iteration counter with WIDTH-1.
  - Latch the result sign (dividend XOR divisor) and the remainder sign (the dividend sign).
  - Magnitudes and signs apply only for signed operation; otherwise operands load raw.
- CALC iteration:
  - Shift {partial remainder, quotient register} left by one.
  - Compute trial = partial remainder − divisor.
  - If trial is non-negative, the partial remainder takes trial and the quotient LSB is 1.
  - Otherwise the partial remainder is kept and the quotient LSB is 0.
  - Decrement the counter; exit after the iteration where counter == 0.
- CALC → DONE transition:
  - Write quotient and remainder registers.
  - Signed: negate the quotient if the result sign is 1; negate the remainder if the remainder sign is 1.
  - div_by_zero = 0.
- Divide by zero: quotient = all ones, remainder = dividend unmodified, div_by_zero = 1, for both signed and unsigned operation.
- Signed overflow (most-negative / −1): quotient = dividend, remainder = 0, div_by_zero = 0. This is the natural result of the magnitude path; no special case is required.
- start while busy: ignored, with no effect on the operation in flight.
- start on the DONE cycle: ignored; a new request is accepted from IDLE only.

## Timing
- Reset (rst_n low at a clock edge):
  - State → IDLE.
  - busy, done, div_by_zero = 0.
  - quotient, remainder = 0.
  - Counter and internal registers = 0.
- Reset mid-operation: aborts on the next edge with the values above; no done pulse is emitted for the aborted operation.
- Start accepted at edge T:
  - Normal divide: busy is high from T+1; done is high in the cycle after edge T+WIDTH+1. Latency is WIDTH+1 cycles.
  - Divide by zero: done is high after edge T+1. Latency is 1 cycle.
- busy falls with the edge that clears done.
- Minimum spacing between accepted starts: WIDTH+2 cycles.
- Outputs change only on the edge that raises done, or on reset.

## Configuration
- DIV_SIGNED_EN defined:
  - signed_op selects two's-complement operation.
  - Includes operand-magnitude and result-negation logic.
  - Latency is unchanged.
- DIV_SIGNED_EN undefined:
  - signed_op is ignored; all operands are unsigned.
  - No negation logic is synthesised.
  - The port stays present so instantiations do not change.

## Test plan
- WIDTH=8, unsigned: 100 / 7 → quotient=14, remainder=2, div_by_zero=0. done exactly 9 cycles after the start edge; busy high 9 cycles.
- WIDTH=8: 0xFF / 0x01 → quotient=0xFF, remainder=0x00. Then 0x03 / 0x10 → quotient=0x00, remainder=0x03.
- WIDTH=8: 0x05 / 0x00 → quotient=0xFF, remainder=0x05, div_by_zero=1. done 1 cycle after start.
- WIDTH=8, DIV_SIGNED_EN, signed_op=1:
  - 0xF9 (−7) / 0x02 → quotient=0xFD (−3), remainder=0xFF (−1).
  - 0x80 / 0xFF → quotient=0x80, remainder=0x00.
  - Same stimulus without the macro: 0xF9 / 0x02 → quotient=0x7C, remainder=0x01.
- Handshake: pulse start again 3 cycles after acceptance with different operands → ignored. First result is unchanged; a single done pulse occurs.
- Reset mid-operation: assert rst_n=0 for one cycle in iteration 4 → all outputs 0 next cycle, no done pulse. A following 100 / 7 completes correctly.
